// File: rtl/fft_frame_capture.sv
// ---------------------------------------------------------------------------
// fft_frame_capture
//   Sink for the FFT output stream. After arm, waits DELAY enable-high cycles
//   for the FFT pipeline to fill, stores the next N enable-high samples of
//   {Xb_re, Xb_im} into two N x DW buffers, then replays the frame over a
//   valid/ready readout interface.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   arm        in   single-cycle pulse that starts a capture (ignored while busy)
//   enable     in   FFT enable; qualifies delay counting and sampling
//   xb_re_in   in   FFT output, real part (signed)
//   xb_im_in   in   FFT output, imaginary part (signed)
//   busy       out  high from accepted arm until the last readout handshake
//   rd_valid   out  readout word valid
//   rd_ready   in   consumer accepts the presented word
//   rd_re      out  captured real part
//   rd_im      out  captured imaginary part
//   rd_index   out  bin index of the presented word
//   rd_last    out  high with index N-1
// ---------------------------------------------------------------------------
module fft_frame_capture #(
    parameter int N     = 1024,
    parameter int DW    = 16,
    parameter int DELAY = 1034
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arm,
    input  logic                   enable,
    input  logic signed [DW-1:0]   xb_re_in,
    input  logic signed [DW-1:0]   xb_im_in,
    output logic                   busy,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic signed [DW-1:0]   rd_re,
    output logic signed [DW-1:0]   rd_im,
    output logic [$clog2(N)-1:0]   rd_index,
    output logic                   rd_last
);

    localparam int IW = $clog2(N);
    // Delay counter must be able to hold DELAY itself.
    localparam int CW = (DELAY > 0) ? $clog2(DELAY + 1) : 1;

    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    // Only meaningful for DELAY >= 1; WAIT is never entered when DELAY == 0.
    localparam logic [CW-1:0] DLY_LAST = CW'(DELAY - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DRAIN   = 2'd3
    } state_e;

    state_e                 state_q;
    logic [CW-1:0]          dcnt_q;
    logic [IW-1:0]          wr_idx_q;
    logic                   busy_q;
    logic                   rd_valid_q;
    logic                   rd_last_q;
    logic [IW-1:0]          rd_index_q;

    // Frame buffers: one write port (CAPTURE) and one read port (DRAIN).
    logic signed [DW-1:0]   mem_re_q [N];
    logic signed [DW-1:0]   mem_im_q [N];
    logic signed [DW-1:0]   ram_re_q;
    logic signed [DW-1:0]   ram_im_q;

    logic                   wr_en_d;
    logic                   load_d;
    logic                   rd_en_d;
    logic                   finish_d;
    logic [IW-1:0]          rd_addr_d;

    // Buffer write strobe and readout-register load control.
    always_comb begin
        wr_en_d   = 1'b0;
        load_d    = 1'b0;
        rd_en_d   = 1'b0;
        finish_d  = 1'b0;
        rd_addr_d = {IW{1'b0}};
        if (state_q == ST_CAPTURE) begin
            wr_en_d = enable;
        end else begin
            wr_en_d = 1'b0;
        end
        // The output word register refills when empty or being consumed, so
        // rd_ready=1 streams one word per cycle without bubbles.
        if (state_q == ST_DRAIN) begin
            load_d = (!rd_valid_q) || rd_ready;
        end else begin
            load_d = 1'b0;
        end
        // Next word to fetch: index 0 on entry, otherwise the successor of
        // the word currently presented.
        if (rd_valid_q) begin
            rd_addr_d = rd_index_q + IW'(1'b1);
        end else begin
            rd_addr_d = {IW{1'b0}};
        end
        // Consuming the last word ends the frame instead of wrapping the index.
        finish_d = load_d && rd_valid_q && rd_last_q;
        rd_en_d  = load_d && !finish_d;
    end

    // Buffer storage: synchronous write in CAPTURE, registered read in DRAIN.
    always_ff @(posedge clk) begin
        if (wr_en_d) begin
            mem_re_q[wr_idx_q] <= xb_re_in;
            mem_im_q[wr_idx_q] <= xb_im_in;
        end
        if (rd_en_d) begin
            ram_re_q <= mem_re_q[rd_addr_d];
            ram_im_q <= mem_im_q[rd_addr_d];
        end
    end

    // Control FSM with its registered status/readout outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            dcnt_q     <= {CW{1'b0}};
            wr_idx_q   <= {IW{1'b0}};
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_index_q <= {IW{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        busy_q   <= 1'b1;
                        dcnt_q   <= {CW{1'b0}};
                        wr_idx_q <= {IW{1'b0}};
                        state_q  <= (DELAY == 0) ? ST_CAPTURE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (enable) begin
                        dcnt_q <= dcnt_q + CW'(1'b1);
                        if (dcnt_q == DLY_LAST) begin
                            state_q <= ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (enable) begin
                        if (wr_idx_q == IDX_LAST) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            wr_idx_q <= wr_idx_q + IW'(1'b1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (finish_d) begin
                        rd_valid_q <= 1'b0;
                        rd_last_q  <= 1'b0;
                        rd_index_q <= {IW{1'b0}};
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else if (load_d) begin
                        rd_valid_q <= 1'b1;
                        rd_index_q <= rd_addr_d;
                        rd_last_q  <= (rd_addr_d == IDX_LAST);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;
    assign rd_index = rd_index_q;
    // The buffer read register carries no reset so it can sit inside a block
    // RAM; qualifying with rd_valid keeps the data outputs at zero whenever no
    // word is presented, including straight out of reset.
    assign rd_re    = rd_valid_q ? ram_re_q : {DW{1'b0}};
    assign rd_im    = rd_valid_q ? ram_im_q : {DW{1'b0}};

endmodule

// File: doc/fft_frame_capture.md
Name: fft_frame_capture

Overview:
- Sink for the FFT_top output stream (Xb_re/Xb_im): captures one N-point frame after a programmable pipeline delay into internal buffers.
- Replays the frame to a downstream consumer (readout/host link) over a valid/ready interface.
- Replaces the fixed wait-then-sample capture loop used at the FFT output, so frames can be retrieved in hardware.

Parameters:
- N, 1024, points per frame; power of two.
- DW, 16, sample width (signed, two's complement).
- DELAY, 1034, enable-high cycles from the first enable after arm to the cycle Xb of bin 0 is captured.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- arm  in  1  single-cycle pulse: start a capture.
- enable  in  1  same enable that drives FFT_top; qualifies delay counting and sampling.
- xb_re_in  in  DW  FFT output real part (Xb_re).
- xb_im_in  in  DW  FFT output imaginary part (Xb_im).
- busy  out  1  high from accepted arm until the last readout handshake.
- rd_valid  out  1  readout word valid.
- rd_ready  in  1  consumer accepts the word.
- rd_re  out  DW  captured real part.
- rd_im  out  DW  captured imaginary part.
- rd_index  out  log2(N)  bin index of the presented word.
- rd_last  out  1  high with index N-1.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; busy=0, rd_valid=0, rd_last=0, rd_re=0, rd_im=0, rd_index=0; counters cleared. Buffer contents are don't-care.
- Reset mid-operation aborts immediately. No partial frame is replayed after release.
- State IDLE:
  - arm=1 goes to WAIT; busy=1 the next cycle.
- State WAIT:
  - The delay counter increments on each cycle with enable=1, starting with the first enable-high cycle at or after the cycle following arm.
  - enable=0 pauses the counter; no reset, no sample.
  - When the counter has seen DELAY enable-high cycles, go to CAPTURE.
  - The next enable-high cycle stores sample index 0.
  - DELAY=0: the first enable-high cycle after arm is captured as index 0; WAIT lasts 0 cycles.
- State CAPTURE:
  - Each enable-high cycle writes {xb_re_in, xb_im_in} to index k, then k increments.
  - enable=0 cycles write nothing and hold k.
  - After index N-1 is written, go to DRAIN.
- State DRAIN:
  - Entering DRAIN, the first word (index 0) is fetched.
  - rd_valid rises at most 2 cycles after the N-1 write.
  - rd_re/rd_im/rd_index/rd_last hold stable while rd_valid=1 and rd_ready=0.
  - On rd_valid&&rd_ready, the next index appears the following cycle with rd_valid kept high: one word per cycle at rd_ready=1, no bubbles.
  - Handshake with rd_last=1: rd_valid=0, rd_last=0, busy=0 the next cycle, state IDLE.
  - rd_valid never depends combinationally on rd_ready.
- arm while busy=1 is ignored: no restart, no counter disturbance.
- arm in the same cycle the final handshake completes is also ignored; arm must be re-pulsed once busy=0.
- Width/arithmetic:
  - Delay counter is ceil(log2(DELAY+1)) bits minimum.
  - Index counter is log2(N) bits and wraps only via the state change, never modularly into a second frame.
  - Samples are stored bit-exact, with no scaling or saturation.
- Storage:
  - Two N x DW memories (re/im), single write port and single read port each, inferable as block RAM.
  - Write and read are never active on the same buffer in the same state, so no read-during-write hazard.

Test Plan:
- Basic capture (N=8, DELAY=4): arm, then enable=1 continuously with xb_re_in=cycle count from 0 and xb_im_in=-(cycle count). Required: rd_re=4..11, rd_im=-4..-11, rd_index=0..7, rd_last only on index 7; busy falls the cycle after that handshake.
- Enable gaps (N=8, DELAY=4): enable toggles 1,0,1,0,… with the same ramp data. Required: only enable-high samples are captured, and the delay counts enable-high cycles only. First captured value is the 5th enable-high sample; stored values are the 5th–12th enable-high samples, in order.
- Backpressure: rd_ready pattern 1,0,0,1,1,0,… during DRAIN. Required: outputs stay stable while stalled; every index 0..7 is delivered exactly once, in order; at rd_ready=1 back-to-back, one word per cycle.
- Arm while busy: second arm pulse mid-WAIT and mid-DRAIN. Required: identical output sequence to the basic test; no second frame.
- Reset mid-CAPTURE: rst=0 for 1 cycle at k=3. Required: all outputs 0 asynchronously, state IDLE. A fresh arm then yields a complete correct frame.
- Default parameters (N=1024, DELAY=1034), FFT_top driven with xb_re=1 and xb_im=0 for 1024 cycles. Required: 1024 words with rd_index 0..1023 match the Xb_re/Xb_im sampled by the bench over cycles 1034..2057 after enable rise.
